// File: rtl/control_unit_pkg.sv
// Mini SRC control unit: opcode map, state encoding, decode helper.
// Shared by the sequencer and the ALU.
package control_unit_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [5:0] {
    S_RESET, S_T0, S_T1, S_T2, S_HALT,
    S_ALU3, S_ALU4, S_ALU5,
    S_IMM3, S_IMM4, S_IMM5,
    S_MD3, S_MD4, S_MD5, S_MD6,
    S_NEG3, S_NEG4,
    S_LDI3, S_LDI4, S_LDI5,
    S_LD3, S_LD4, S_LD5, S_LD6, S_LD7,
    S_ST3, S_ST4, S_ST5, S_ST6, S_ST7,
    S_BR3, S_BR4, S_BR5, S_BR6,
    S_JR3, S_JAL3, S_JAL4,
    S_IN3, S_OUT3, S_MFHI3, S_MFLO3
  } state_t;

  // First execute state for an opcode; nop and undefined codes
  // go straight back to fetch unless Stop is raised.
  function automatic state_t decode(
    input logic [4:0] op,
    input logic       stop
  );
    state_t s;
    unique case (1'b1)
      (op >= OP_ADD && op <= OP_SHL):  s = S_ALU3;
      (op >= OP_ADDI && op <= OP_ORI): s = S_IMM3;
      (op == OP_DIV || op == OP_MUL):  s = S_MD3;
      (op == OP_NEG || op == OP_NOT):  s = S_NEG3;
      (op == OP_LD):   s = S_LD3;
      (op == OP_LDI):  s = S_LDI3;
      (op == OP_ST):   s = S_ST3;
      (op == OP_BR):   s = S_BR3;
      (op == OP_JR):   s = S_JR3;
      (op == OP_JAL):  s = S_JAL3;
      (op == OP_IN):   s = S_IN3;
      (op == OP_OUT):  s = S_OUT3;
      (op == OP_MFHI): s = S_MFHI3;
      (op == OP_MFLO): s = S_MFLO3;
      (op == OP_HALT): s = S_HALT;
      default:         s = stop ? S_HALT : S_T0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Mini SRC sequencer: fetch, decode, per-class execute, halt.
// Moore outputs except br T6 PCin, gated by CON_FF.
module control_unit
  import control_unit_pkg::*;
#(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stop,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        BAout,
  output logic        InPortout,
  output logic        Cout,
  output logic        PCin,
  output logic        Zin,
  output logic        MDRin,
  output logic        MARin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        IRin,
  output logic        OutPortin,
  output logic        CONin,
  output logic        Rin,
  output logic        Rout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  opcode,
  output logic        Run
);

  state_t state;
  state_t state_n;

  logic [4:0] ir_op;
  logic       ir_unused;

  assign ir_op     = IR[31:27];
  assign ir_unused = ^IR[26:0];

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_RESET;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_RESET: state_n = S_T0;
      S_T0:    state_n = S_T1;
      S_T1:    state_n = S_T2;
      S_T2:    state_n = decode(ir_op, Stop);
      S_HALT:  state_n = S_HALT;
      S_ALU3:  state_n = S_ALU4;
      S_ALU4:  state_n = S_ALU5;
      S_IMM3:  state_n = S_IMM4;
      S_IMM4:  state_n = S_IMM5;
      S_MD3:   state_n = S_MD4;
      S_MD4:   state_n = S_MD5;
      S_MD5:   state_n = S_MD6;
      S_NEG3:  state_n = S_NEG4;
      S_LDI3:  state_n = S_LDI4;
      S_LDI4:  state_n = S_LDI5;
      S_LD3:   state_n = S_LD4;
      S_LD4:   state_n = S_LD5;
      S_LD5:   state_n = S_LD6;
      S_LD6:   state_n = S_LD7;
      S_ST3:   state_n = S_ST4;
      S_ST4:   state_n = S_ST5;
      S_ST5:   state_n = S_ST6;
      S_ST6:   state_n = S_ST7;
      S_BR3:   state_n = S_BR4;
      S_BR4:   state_n = S_BR5;
      S_BR5:   state_n = S_BR6;
      S_JAL3:  state_n = S_JAL4;
      S_ALU5, S_IMM5, S_MD6, S_NEG4,
      S_LDI5, S_LD7, S_ST7, S_BR6,
      S_JR3, S_JAL4, S_IN3, S_OUT3,
      S_MFHI3, S_MFLO3:
        state_n = Stop ? S_HALT : S_T0;
      default: state_n = S_RESET;
    endcase
  end

  always_comb begin
    {PCout, Zhighout, Zlowout, MDRout,
     HIout, LOout, BAout, InPortout,
     Cout} = '0;
    {PCin, Zin, MDRin, MARin, Yin, HIin,
     LOin, IRin, OutPortin, CONin,
     Rin, Rout} = '0;
    {Gra, Grb, Grc} = '0;
    {IncPC, Read, Write} = '0;
    unique case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1;
        IncPC = 1'b1;
      end
      S_T1, S_LD6: begin
        Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_ALU3, S_IMM3: begin
        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
      end
      S_ALU4: begin
        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
      end
      S_IMM4, S_LDI4, S_LD4, S_ST4, S_BR5: begin
        Cout = 1'b1; Zin = 1'b1;
      end
      S_ALU5, S_IMM5, S_LDI5, S_NEG4: begin
        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
      end
      S_MD3: begin
        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
      end
      S_MD4, S_NEG3: begin
        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
      end
      S_MD5: begin
        Zlowout = 1'b1; LOin = 1'b1;
      end
      S_MD6: begin
        Zhighout = 1'b1; HIin = 1'b1;
      end
      S_LDI3, S_LD3, S_ST3: begin
        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
      end
      S_LD5, S_ST5: begin
        Zlowout = 1'b1; MARin = 1'b1;
      end
      S_LD7: begin
        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
      end
      S_ST6: begin
        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
      end
      S_ST7: Write = 1'b1;
      S_BR3: begin
        Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
      end
      S_BR4: begin
        PCout = 1'b1; Yin = 1'b1;
      end
      S_BR6: begin
        Zlowout = 1'b1; PCin = CON_FF;
      end
      S_JR3, S_JAL4: begin
        Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
      end
      S_JAL3: begin
        PCout = 1'b1; Grb = 1'b1; Rin = 1'b1;
      end
      S_IN3: begin
        InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
      end
      S_OUT3: begin
        Gra = 1'b1; Rout = 1'b1;
        OutPortin = 1'b1;
      end
      S_MFHI3: begin
        HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
      end
      S_MFLO3: begin
        LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    opcode = ir_op;
    Run    = 1'b1;
    unique case (state)
      S_RESET: begin
        opcode = 5'b00000; Run = 1'b0;
      end
      S_HALT: Run = 1'b0;
      S_LDI4, S_LD4, S_ST4, S_BR5:
        opcode = ADD_OP;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table-driven step model, directed
// scenarios with literal pins, then randomized instruction stream.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Stop = 1'b0;
  logic        CON_FF = 1'b0;
  logic [31:0] IR = 32'h0;

  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic BAout, InPortout, Cout;
  logic PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin;
  logic OutPortin, CONin, Rin, Rout;
  logic Gra, Grb, Grc, IncPC, Read, Write, Run;
  logic [4:0] opcode;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .Stop(Stop),
    .IR(IR), .CON_FF(CON_FF),
    .PCout(PCout), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .BAout(BAout),
    .InPortout(InPortout), .Cout(Cout),
    .PCin(PCin), .Zin(Zin), .MDRin(MDRin),
    .MARin(MARin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .IRin(IRin),
    .OutPortin(OutPortin), .CONin(CONin),
    .Rin(Rin), .Rout(Rout), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .IncPC(IncPC), .Read(Read),
    .Write(Write), .opcode(opcode), .Run(Run)
  );

  always #5 Clock = ~Clock;

  localparam logic [26:0] WR   = 27'h1 << 0;
  localparam logic [26:0] RD   = 27'h1 << 1;
  localparam logic [26:0] INC  = 27'h1 << 2;
  localparam logic [26:0] GRC  = 27'h1 << 3;
  localparam logic [26:0] GRB  = 27'h1 << 4;
  localparam logic [26:0] GRA  = 27'h1 << 5;
  localparam logic [26:0] ROUT = 27'h1 << 6;
  localparam logic [26:0] RIN  = 27'h1 << 7;
  localparam logic [26:0] CONI = 27'h1 << 8;
  localparam logic [26:0] OUTI = 27'h1 << 9;
  localparam logic [26:0] IRI  = 27'h1 << 10;
  localparam logic [26:0] LOI  = 27'h1 << 11;
  localparam logic [26:0] HII  = 27'h1 << 12;
  localparam logic [26:0] YIN  = 27'h1 << 13;
  localparam logic [26:0] MARI = 27'h1 << 14;
  localparam logic [26:0] MDRI = 27'h1 << 15;
  localparam logic [26:0] ZIN  = 27'h1 << 16;
  localparam logic [26:0] PCI  = 27'h1 << 17;
  localparam logic [26:0] COUT = 27'h1 << 18;
  localparam logic [26:0] INO  = 27'h1 << 19;
  localparam logic [26:0] BAO  = 27'h1 << 20;
  localparam logic [26:0] LOO  = 27'h1 << 21;
  localparam logic [26:0] HIO  = 27'h1 << 22;
  localparam logic [26:0] MDRO = 27'h1 << 23;
  localparam logic [26:0] ZLO  = 27'h1 << 24;
  localparam logic [26:0] ZHI  = 27'h1 << 25;
  localparam logic [26:0] PCO  = 27'h1 << 26;

  localparam int M_X = 0, M_RST = 1;
  localparam int M_RUN = 2, M_HALT = 3;

  int total = 0;
  int bad = 0;
  int mmode = M_X;
  int mk = 0;
  logic [4:0] mop = 5'd0;

  function automatic logic [26:0] ctl();
    return {PCout, Zhighout, Zlowout, MDRout,
            HIout, LOout, BAout, InPortout, Cout,
            PCin, Zin, MDRin, MARin, Yin, HIin,
            LOin, IRin, OutPortin, CONin, Rin, Rout,
            Gra, Grb, Grc, IncPC, Read, Write};
  endfunction

  // Cycles per instruction, counting the three fetch cycles.
  function automatic int nsteps(logic [4:0] op);
    if (op inside {[5'd3:5'd14]}) return 6;
    if (op == 5'd1) return 6;
    if (op inside {5'd0, 5'd2}) return 8;
    if (op inside {5'd15, 5'd16}) return 7;
    if (op inside {5'd17, 5'd18}) return 5;
    if (op == 5'd19) return 7;
    if (op == 5'd21) return 5;
    if (op inside {[5'd20:5'd25]}) return 4;
    return 3;
  endfunction

  function automatic logic [26:0] exp_ctl(
    int k, logic [4:0] op, logic con);
    logic [26:0] v;
    v = '0;
    if (k == 0) v = PCO | MARI | INC;
    else if (k == 1) v = RD | MDRI;
    else if (k == 2) v = MDRO | IRI;
    else if (op inside {[5'd3:5'd14]}) begin
      if (k == 3) v = GRB | ROUT | YIN;
      if (k == 4) v = (op <= 5'd11) ?
        (GRC | ROUT | ZIN) : (COUT | ZIN);
      if (k == 5) v = ZLO | GRA | RIN;
    end else if (op inside {5'd15, 5'd16}) begin
      if (k == 3) v = GRA | ROUT | YIN;
      if (k == 4) v = GRB | ROUT | ZIN;
      if (k == 5) v = ZLO | LOI;
      if (k == 6) v = ZHI | HII;
    end else if (op inside {5'd17, 5'd18}) begin
      if (k == 3) v = GRB | ROUT | ZIN;
      if (k == 4) v = ZLO | GRA | RIN;
    end else if (op inside {5'd0, 5'd1, 5'd2}) begin
      if (k == 3) v = GRB | BAO | YIN;
      if (k == 4) v = COUT | ZIN;
      if (k == 5) v = (op == 5'd1) ?
        (ZLO | GRA | RIN) : (ZLO | MARI);
      if (k == 6) v = (op == 5'd0) ?
        (RD | MDRI) : (GRA | ROUT | MDRI);
      if (k == 7) v = (op == 5'd0) ?
        (MDRO | GRA | RIN) : WR;
    end else if (op == 5'd19) begin
      if (k == 3) v = GRA | ROUT | CONI;
      if (k == 4) v = PCO | YIN;
      if (k == 5) v = COUT | ZIN;
      if (k == 6) v = ZLO | (con ? PCI : 27'h0);
    end else if (op == 5'd20) v = GRA | ROUT | PCI;
    else if (op == 5'd21)
      v = (k == 3) ? (PCO | GRB | RIN) : (GRA | ROUT | PCI);
    else if (op == 5'd22) v = INO | GRA | RIN;
    else if (op == 5'd23) v = GRA | ROUT | OUTI;
    else if (op == 5'd24) v = HIO | GRA | RIN;
    else if (op == 5'd25) v = LOO | GRA | RIN;
    return v;
  endfunction

  always @(posedge Clock) begin
    if (Reset) mmode <= M_RST;
    else if (mmode == M_RST) begin
      mmode <= M_RUN;
      mk <= 0;
    end else if (mmode == M_RUN) begin
      if (mk == 2) mop <= IR[31:27];
      if (mk == 2 && IR[31:27] == 5'd27)
        mmode <= M_HALT;
      else if (mk == nsteps(mk == 2 ?
                 IR[31:27] : mop) - 1) begin
        mk <= 0;
        if (Stop) mmode <= M_HALT;
      end else mk <= mk + 1;
    end
  end

  always @(negedge Clock) begin
    logic [26:0] ec;
    logic [4:0]  eo;
    logic        er;
    if (mmode != M_X) begin
      ec = '0;
      eo = IR[31:27];
      er = 1'b0;
      if (mmode == M_RST) eo = 5'd0;
      if (mmode == M_RUN) begin
        er = 1'b1;
        ec = exp_ctl(mk, mk >= 3 ? mop : IR[31:27],
                     CON_FF);
        if ((mk == 4 && mop <= 5'd2) ||
            (mk == 5 && mop == 5'd19))
          eo = 5'd3;
      end
      total++;
      if (ctl() !== ec || opcode !== eo || Run !== er) begin
        bad++;
        $display("FAIL model t=%0t got=%h/%h/%b want=%h/%h/%b",
                 $time, ctl(), opcode, Run, ec, eo, er);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #3;
    end
  endtask

  task automatic lit(string nm, logic [31:0] got,
                     logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  logic seen;
  int   hcnt;

  initial begin
    tick(2);
    lit("rst_ctl", 32'(ctl()), 32'h0);
    lit("rst_run", 32'(Run), 32'h0);
    lit("rst_op", 32'(opcode), 32'h0);
    Reset = 1'b0;
    tick();
    lit("t0_ctl", 32'(ctl()), 32'(PCO | MARI | INC));
    lit("t0_run", 32'(Run), 32'h1);

    IR = 32'h69180025;
    tick(3);
    lit("andi_t3", 32'(ctl()), 32'(GRB | ROUT | YIN));
    tick();
    lit("andi_t4", 32'(ctl()), 32'(COUT | ZIN));
    lit("andi_op", 32'(opcode), 32'h0D);
    tick();
    lit("andi_t5", 32'(ctl()), 32'(ZLO | GRA | RIN));
    tick();
    lit("andi_t0", 32'(ctl()), 32'(PCO | MARI | INC));

    IR = 32'h00800055;
    tick(4);
    lit("ld_op", 32'(opcode), 32'h03);
    tick(2);
    lit("ld_t6", 32'(ctl()), 32'(RD | MDRI));
    tick();
    lit("ld_t7", 32'(ctl()), 32'(MDRO | GRA | RIN));
    tick();
    lit("ld_t0", 32'(ctl()), 32'(PCO | MARI | INC));

    for (int c = 0; c < 2; c++) begin
      IR = 32'h98800000;
      CON_FF = c[0];
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        seen |= PCin;
      end
      lit("br_t6", 32'(ctl()), 32'(ZLO | (c == 1 ? PCI : 27'h0)));
      lit("br_pcin", 32'(seen), 32'(c));
      tick();
    end
    CON_FF = 1'b0;

    IR = 32'h10800000;
    tick(6);
    lit("st_t6", 32'(ctl()), 32'(GRA | ROUT | MDRI));
    Reset = 1'b1;
    tick();
    lit("st_rst", 32'(ctl()), 32'h0);
    Reset = 1'b0;
    tick();
    lit("st_t0", 32'(ctl()), 32'(PCO | MARI | INC));

    IR = 32'h18000000;
    tick(5);
    lit("add_t5", 32'(ctl()), 32'(ZLO | GRA | RIN));
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    lit("stop_halt", 32'(Run), 32'h0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();

    IR = 32'hD8000000;
    tick(2);
    lit("halt_t2", 32'(Run), 32'h1);
    hcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      hcnt += int'(Run);
    end
    lit("halt_20", 32'(hcnt), 32'h0);

    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    hcnt = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      Stop = ($urandom_range(0, 7) == 0);
      CON_FF = 1'($urandom);
      hcnt = (mmode == M_HALT) ? hcnt + 1 : 0;
      Reset = ($urandom_range(0, 63) == 0) || hcnt > 3;
      if (mmode == M_RUN && mk == 0)
        IR = {5'($urandom_range(0, 31)), 27'($urandom)};
    end
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
